ov7670_rgb444_capture: RTL and testbench
========================================

OV7670_RGB444_CAPTURE -- requirements
Module: ov7670_rgb444_capture

Interface
REQ-001 Parameter H_ACTIVE, default 640, pixels per camera line; sizes the column counter.
REQ-002 Parameter V_ACTIVE, default 480, lines per frame; sizes the row counter.
REQ-003 Parameter FIFO_DEPTH, default 2, output buffer entries; power of two, 2 or more.
REQ-004 clk  in  1  single clock, camera PCLK rate; all logic on its rising edge.
REQ-005 rst_n  in  1  reset, synchronous and active-low.
REQ-006 cam_vsync  in  1  camera VSYNC, high = vertical blanking.
REQ-007 cam_href  in  1  camera HREF, high = valid line bytes.
REQ-008 cam_data  in  8  camera byte bus.
REQ-009 rgb  out  12  pixel to encoder, {R,G,B} 4 bits each.
REQ-010 en  out  1  pixel valid; drives encoder en.
REQ-011 ready  in  1  encoder accepts pixel; a transfer occurs when en and ready are high in the same cycle.
REQ-012 frame_start  out  1  one-cycle pulse on the first transferred pixel of a frame.
REQ-013 frame_done  out  1  one-cycle pulse at end of frame.
REQ-014 col  out  $clog2(H_ACTIVE)  column of the pixel on rgb.
REQ-015 row  out  $clog2(V_ACTIVE)  row of the pixel on rgb.
REQ-016 overflow  out  1  sticky: a pixel was dropped because the FIFO was full.
REQ-017 line_err  out  1  sticky: HREF fell on an odd byte count.

Function
REQ-018 FSM states: SYNC (wait for cam_vsync rising edge), BLANK (wait for cam_vsync low), ACTIVE (capture).
REQ-019 Transitions: SYNC to BLANK on vsync rise; BLANK to ACTIVE on vsync low; ACTIVE to BLANK on vsync rise, with frame_done pulsed in that same cycle.
REQ-020 cam_* inputs are registered once before use, so pipeline latency is counted from the registered copy.
REQ-021 In ACTIVE with href high: byte 0 latches R = data[3:0]; byte 1 forms {R, data[7:4], data[3:0]} and pushes it to the FIFO.
REQ-022 The byte phase clears whenever href is low.
REQ-023 If href falls while phase = 1, the partial byte is discarded and line_err is set.
REQ-024 col increments per assembled pixel and clears on href fall.
REQ-025 row increments on href fall and clears on entering ACTIVE.
REQ-026 col and row saturate at H_ACTIVE-1 and V_ACTIVE-1 respectively.
REQ-027 Each FIFO entry holds {rgb, col, row, first}; first marks the first pixel of the frame.
REQ-028 en = FIFO not empty; rgb, col and row show the FIFO head.
REQ-029 frame_start = en AND ready AND head.first.
REQ-030 Latency from the second byte on cam_data to en high is 2 cycles when the FIFO is empty.
REQ-031 Push and pop in the same cycle with the FIFO full: both succeed and nothing is dropped.
REQ-032 Push with the FIFO full and no pop: the pixel is dropped and overflow is set.
REQ-033 Pixels still in the FIFO at frame_done drain normally.
REQ-034 Bytes in SYNC or BLANK are ignored.

Reset
REQ-035 With rst_n low at a clk edge: state SYNC, FIFO empty, phase 0, col and row 0.
REQ-036 With rst_n low at a clk edge: en, frame_start, frame_done, overflow, line_err and rgb all 0.
REQ-037 Reset mid-frame discards all buffered pixels; capture resumes only after the next full vsync rise and fall.
REQ-038 The sticky flags clear only on reset.

Configuration
REQ-039 Macro OV7670_DECIM2_EN, when defined, keeps only pixels with even col on rows with even row (320x240 from 640x480).
REQ-040 With OV7670_DECIM2_EN defined, reported col and row are halved and first marks pixel (0,0).
REQ-041 Without OV7670_DECIM2_EN, every pixel is forwarded with no decimation logic present.

Structure
REQ-042 Package ov7670_pkg holds the FSM state enum, the FIFO entry struct and RGB444 field widths.
REQ-043 The FIFO is sub-module capture_fifo (parameterized width and depth, synchronous active-low reset), shared with future stages.

Verification
REQ-044 Reset, vsync pulse, one line of bytes 0x0F,0xFF,0x0F,0xF0, ready=1 -> rgb 0xFFF then 0xFF0, col 0 then 1, frame_start once on the first pixel.
REQ-045 ready=0 for a line of 4 pixels 0xF0F,0x0FF,0xF0F,0xFF0 -> first 2 are held, last 2 dropped, overflow=1; after ready=1, 0xF0F then 0x0FF are delivered.
REQ-046 HREF drops after 3 bytes (0x0F,0x0E,0x0D) -> one pixel 0xF0E, line_err=1, row advances to 1.
REQ-047 rst_n low for 1 cycle mid-line -> en=0 next cycle; bytes are ignored until the next vsync rise and fall.
REQ-048 A 4x2 frame followed by vsync rise -> frame_done pulses once, 8 pixels transfer, row goes 0 then 1; with OV7670_DECIM2_EN only (0,0) and (1,0) are delivered.

Source files
------------

// File: rtl/ov7670_pkg.sv
// Shared types for the OV7670 RGB444 capture path: FSM states, FIFO entry layout,
// RGB444 field widths.
package ov7670_pkg;

    localparam int R_W   = 4;
    localparam int G_W   = 4;
    localparam int B_W   = 4;
    localparam int RGB_W = R_W + G_W + B_W;

    // Coordinate field width in a FIFO entry; wide enough for any practical sensor mode.
    localparam int CRD_W = 12;

    typedef enum logic [1:0] {
        ST_SYNC   = 2'd0,
        ST_BLANK  = 2'd1,
        ST_ACTIVE = 2'd2
    } cap_state_e;

    typedef struct packed {
        logic [RGB_W-1:0] rgb;
        logic [CRD_W-1:0] col;
        logic [CRD_W-1:0] row;
        logic             first;
    } cap_entry_t;

endpackage

// File: rtl/capture_fifo.sv
// Small synchronous FIFO; a push into a full FIFO succeeds when a pop happens in the
// same cycle. Head data reads as zero while empty.
module capture_fifo #(
    parameter int WIDTH = 8,
    parameter int DEPTH = 2
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             i_wr,
    input  logic [WIDTH-1:0] i_wdata,
    input  logic             i_rd,
    output logic [WIDTH-1:0] o_rdata,
    output logic             o_full,
    output logic             o_empty
);
    localparam int AW = $clog2(DEPTH);

    logic [WIDTH-1:0] r_mem [DEPTH];
    logic [AW-1:0]    r_wp;
    logic [AW-1:0]    r_rp;
    logic [AW:0]      r_cnt;
    logic             w_wr;
    logic             w_rd;

    assign o_empty = (r_cnt == '0);
    assign o_full  = (r_cnt == (AW+1)'(DEPTH));
    assign w_rd    = i_rd & ~o_empty;
    assign w_wr    = i_wr & (~o_full | w_rd);
    assign o_rdata = o_empty ? '0 : r_mem[r_rp];

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            r_wp  <= '0;
            r_rp  <= '0;
            r_cnt <= '0;
        end else begin
            if (w_wr) r_wp <= r_wp + AW'(1);
            if (w_rd) r_rp <= r_rp + AW'(1);
            r_cnt <= r_cnt + (AW+1)'(w_wr) - (AW+1)'(w_rd);
        end
    end

    always_ff @(posedge clk) begin
        if (w_wr) r_mem[r_wp] <= i_wdata;
    end

endmodule

// File: rtl/ov7670_rgb444_capture.sv
// OV7670 RGB444 byte-pair capture into a small pixel FIFO with ready/valid output.
// Define OV7670_DECIM2_EN to keep only even-col/even-row pixels with halved coordinates.
module ov7670_rgb444_capture
    import ov7670_pkg::*;
#(
    parameter int H_ACTIVE   = 640,
    parameter int V_ACTIVE   = 480,
    parameter int FIFO_DEPTH = 2
) (
    input  logic                        clk,
    input  logic                        rst_n,
    input  logic                        cam_vsync,
    input  logic                        cam_href,
    input  logic [7:0]                  cam_data,
    output logic [RGB_W-1:0]            rgb,
    output logic                        en,
    input  logic                        ready,
    output logic                        frame_start,
    output logic                        frame_done,
    output logic [$clog2(H_ACTIVE)-1:0] col,
    output logic [$clog2(V_ACTIVE)-1:0] row,
    output logic                        overflow,
    output logic                        line_err
);
    localparam int COL_W = $clog2(H_ACTIVE);
    localparam int ROW_W = $clog2(V_ACTIVE);
    localparam logic [COL_W-1:0] COL_MAX = COL_W'(H_ACTIVE - 1);
    localparam logic [ROW_W-1:0] ROW_MAX = ROW_W'(V_ACTIVE - 1);

    logic             r_vsync, r_vsync_d, r_href, r_href_d;
    logic [7:0]       r_data;
    cap_state_e       r_state;
    logic             r_phase;
    logic [R_W-1:0]   r_red;
    logic [COL_W-1:0] r_col;
    logic [ROW_W-1:0] r_row;
    logic             r_first_pend;
    logic             r_overflow;
    logic             r_line_err;

    logic             w_vs_rise, w_href_fall, w_active;
    logic             w_keep, w_push, w_pop, w_full, w_empty;
    logic [COL_W-1:0] w_col_rpt;
    logic [ROW_W-1:0] w_row_rpt;
    cap_entry_t       w_wentry;
    cap_entry_t       w_head;

    // vsync history resets high so a pulse already in progress is not taken as a fresh rise.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            r_vsync   <= 1'b1;
            r_vsync_d <= 1'b1;
            r_href    <= 1'b0;
            r_href_d  <= 1'b0;
            r_data    <= '0;
        end else begin
            r_vsync   <= cam_vsync;
            r_vsync_d <= r_vsync;
            r_href    <= cam_href;
            r_href_d  <= r_href;
            r_data    <= cam_data;
        end
    end

    assign w_vs_rise   = r_vsync & ~r_vsync_d;
    assign w_href_fall = r_href_d & ~r_href;
    assign w_active    = (r_state == ST_ACTIVE);

    always_comb begin
`ifdef OV7670_DECIM2_EN
        w_keep    = ~r_col[0] & ~r_row[0];
        w_col_rpt = r_col >> 1;
        w_row_rpt = r_row >> 1;
`else
        w_keep    = 1'b1;
        w_col_rpt = r_col;
        w_row_rpt = r_row;
`endif
    end

    assign w_push = w_active & r_href & r_phase & w_keep;
    assign w_pop  = ~w_empty & ready;

    always_comb begin
        w_wentry.rgb   = {r_red, r_data};
        w_wentry.col   = CRD_W'(w_col_rpt);
        w_wentry.row   = CRD_W'(w_row_rpt);
        w_wentry.first = r_first_pend;
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            r_state      <= ST_SYNC;
            r_phase      <= 1'b0;
            r_red        <= '0;
            r_col        <= '0;
            r_row        <= '0;
            r_first_pend <= 1'b0;
            r_overflow   <= 1'b0;
            r_line_err   <= 1'b0;
        end else begin
            if (w_push && w_full && !w_pop) r_overflow <= 1'b1;
            if (w_push) r_first_pend <= 1'b0;
            case (r_state)
                ST_SYNC: begin
                    if (w_vs_rise) r_state <= ST_BLANK;
                end
                ST_BLANK: begin
                    if (!r_vsync) begin
                        r_state      <= ST_ACTIVE;
                        r_col        <= '0;
                        r_row        <= '0;
                        r_phase      <= 1'b0;
                        r_first_pend <= 1'b1;
                    end
                end
                ST_ACTIVE: begin
                    if (w_vs_rise) r_state <= ST_BLANK;
                    if (r_href) begin
                        r_phase <= ~r_phase;
                        if (!r_phase) r_red <= r_data[3:0];
                        else if (r_col != COL_MAX) r_col <= r_col + COL_W'(1);
                    end else begin
                        r_phase <= 1'b0;
                        // A fall on phase 1 leaves a half pixel behind; it is simply abandoned.
                        if (w_href_fall) begin
                            r_col <= '0;
                            if (r_row != ROW_MAX) r_row <= r_row + ROW_W'(1);
                            if (r_phase) r_line_err <= 1'b1;
                        end
                    end
                end
                default: r_state <= ST_SYNC;
            endcase
        end
    end

    capture_fifo #(
        .WIDTH ($bits(cap_entry_t)),
        .DEPTH (FIFO_DEPTH)
    ) u_fifo (
        .clk     (clk),
        .rst_n   (rst_n),
        .i_wr    (w_push),
        .i_wdata (w_wentry),
        .i_rd    (ready),
        .o_rdata (w_head),
        .o_full  (w_full),
        .o_empty (w_empty)
    );

    assign en          = ~w_empty;
    assign rgb         = w_head.rgb;
    assign col         = COL_W'(w_head.col);
    assign row         = ROW_W'(w_head.row);
    assign frame_start = w_pop & w_head.first;
    assign frame_done  = w_active & w_vs_rise;
    assign overflow    = r_overflow;
    assign line_err    = r_line_err;

endmodule

// File: tb/tb_ov7670_rgb444_capture.sv
// Bench for ov7670_rgb444_capture: frame/line-level pixel model with cycle-accurate
// push schedule, directed scenarios plus random frames with random ready.
module tb_ov7670_rgb444_capture;
    localparam int H = 4;
    localparam int V = 4;
    localparam int D = 2;

    logic        clk = 1'b0;
    logic        rst_n, cam_vsync, cam_href, ready;
    logic [7:0]  cam_data;
    logic [11:0] rgb;
    logic        en, frame_start, frame_done, overflow, line_err;
    logic [1:0]  col, row;

    typedef struct { logic [11:0] rgb; int col; int row; bit first; } pix_t;
    typedef struct { int at; pix_t p; } sched_t;

    pix_t       mq[$];
    sched_t     sq[$];
    pix_t       got[$];
    logic [7:0] lb[$];

    int cyc = 0, fd_at = -1, le_at = -1;
    bit ovf_exp = 0, le_exp = 0;
    int n_chk = 0, n_fail = 0, fs_cnt = 0, fd_cnt = 0;
    bit act = 0, first_pend = 0, rnd_ready = 0;
    int line_no = 0;

    ov7670_rgb444_capture #(.H_ACTIVE(H), .V_ACTIVE(V), .FIFO_DEPTH(D)) dut (
        .clk(clk), .rst_n(rst_n), .cam_vsync(cam_vsync), .cam_href(cam_href),
        .cam_data(cam_data), .rgb(rgb), .en(en), .ready(ready),
        .frame_start(frame_start), .frame_done(frame_done), .col(col), .row(row),
        .overflow(overflow), .line_err(line_err)
    );

    always #5 clk = ~clk;

    task automatic chk(input string nm, input logic [31:0] a, input logic [31:0] e);
        n_chk++;
        if (a !== e) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h (cycle %0d)", nm, a, e, cyc);
        end
    endtask

    // Model: FIFO of expected pixels fed by the driver's push schedule.
    always @(posedge clk) begin
        cyc = cyc + 1;
        if (!rst_n) begin
            mq.delete(); sq.delete();
            ovf_exp = 0; le_exp = 0; fd_at = -1; le_at = -1;
        end else begin
            if (mq.size() > 0 && ready) void'(mq.pop_front());
            while (sq.size() > 0 && sq[0].at == cyc) begin
                if (mq.size() < D) mq.push_back(sq[0].p);
                else ovf_exp = 1;
                void'(sq.pop_front());
            end
            if (le_at == cyc) le_exp = 1;
        end
    end

    always @(negedge clk) begin
        bit   hv;
        pix_t t;
        hv = (mq.size() > 0);
        chk("en", 32'(en), 32'(hv));
        if (hv) begin
            chk("rgb", 32'(rgb), 32'(mq[0].rgb));
            chk("col", 32'(col), 32'(mq[0].col));
            chk("row", 32'(row), 32'(mq[0].row));
        end
        chk("frame_start", 32'(frame_start), 32'(hv ? (ready && mq[0].first) : 1'b0));
        chk("frame_done", 32'(frame_done), 32'(cyc == fd_at));
        chk("overflow", 32'(overflow), 32'(ovf_exp));
        chk("line_err", 32'(line_err), 32'(le_exp));
        if (en && ready) begin
            t.rgb = rgb; t.col = int'(col); t.row = int'(row); t.first = frame_start;
            got.push_back(t);
        end
        if (frame_start) fs_cnt++;
        if (frame_done) fd_cnt++;
    end

    task automatic tick();
        @(posedge clk);
        #1;
        if (rnd_ready) ready = 1'($urandom_range(0, 1));
    endtask

    task automatic vs_pulse();
        tick();
        cam_href = 0; cam_vsync = 1;
        if (act) fd_at = cyc + 1;
        repeat (3) tick();
        cam_vsync = 0; act = 1; line_no = 0; first_pend = 1;
        repeat (4) tick();
    endtask

    // Byte pair driven with its second byte at cycle k lands in the FIFO at edge k+2.
    task automatic sched(input logic [7:0] b0, input logic [7:0] b1, input int pi);
        sched_t s;
        int rc, rr;
        bit keep;
        rc = (pi < H - 1) ? pi : H - 1;
        rr = (line_no < V - 1) ? line_no : V - 1;
        keep = 1;
        s.p.col = rc; s.p.row = rr;
`ifdef OV7670_DECIM2_EN
        keep = (rc % 2 == 0) && (rr % 2 == 0);
        s.p.col = rc / 2; s.p.row = rr / 2;
`endif
        if (keep) begin
            s.at = cyc + 2;
            s.p.rgb = {b0[3:0], b1};
            s.p.first = first_pend;
            first_pend = 0;
            sq.push_back(s);
        end
    endtask

    task automatic send_line(input int rst_at);
        int n;
        n = lb.size();
        if (n == 0) return;
        for (int i = 0; i < n; i++) begin
            tick();
            rst_n = (i == rst_at) ? 1'b0 : 1'b1;
            if (i == rst_at) act = 0;
            cam_href = 1; cam_data = lb[i];
            if (i % 2 == 1 && act) sched(lb[i-1], lb[i], i / 2);
        end
        tick();
        rst_n = 1; cam_href = 0; cam_data = 0;
        if (act) begin
            if (n % 2 == 1) le_at = cyc + 2;
            line_no++;
        end
        repeat (3) tick();
    endtask

    task automatic drain();
        rnd_ready = 0;
        tick();
        ready = 1;
        repeat (8) tick();
    endtask

    initial begin
        int nl, nb;
        rst_n = 0; cam_vsync = 0; cam_href = 0; cam_data = 0; ready = 0;
        tick(); tick();
        rst_n = 1;
        tick();

        // Basic line, ready high
        got.delete(); fs_cnt = 0; ready = 1;
        vs_pulse();
        lb = '{8'h0F, 8'hFF, 8'h0F, 8'hF0};
        send_line(-1);
        drain();
`ifdef OV7670_DECIM2_EN
        chk("t1_count", 32'(got.size()), 32'd1);
`else
        chk("t1_count", 32'(got.size()), 32'd2);
        if (got.size() > 1) begin
            chk("t1_rgb1", 32'(got[1].rgb), 32'hFF0);
            chk("t1_col1", 32'(got[1].col), 32'd1);
        end
`endif
        if (got.size() > 0) begin
            chk("t1_rgb0", 32'(got[0].rgb), 32'hFFF);
            chk("t1_col0", 32'(got[0].col), 32'd0);
        end
        chk("t1_fs_cnt", 32'(fs_cnt), 32'd1);

        // Overflow with ready held low
        vs_pulse();
        got.delete(); ready = 0;
        lb = '{8'h0F, 8'h0F, 8'h00, 8'hFF, 8'h0F, 8'h0F, 8'h0F, 8'hF0};
        send_line(-1);
        chk("t2_held", 32'(got.size()), 32'd0);
        chk("t2_en", 32'(en), 32'd1);
`ifdef OV7670_DECIM2_EN
        chk("t2_overflow", 32'(overflow), 32'd0);
        drain();
        chk("t2_count", 32'(got.size()), 32'd2);
        if (got.size() > 1) chk("t2_rgb1", 32'(got[1].rgb), 32'hF0F);
`else
        chk("t2_overflow", 32'(overflow), 32'd1);
        drain();
        chk("t2_count", 32'(got.size()), 32'd2);
        if (got.size() > 1) chk("t2_rgb1", 32'(got[1].rgb), 32'h0FF);
`endif
        if (got.size() > 0) chk("t2_rgb0", 32'(got[0].rgb), 32'hF0F);

        // Odd-length line then a normal line
        vs_pulse();
        got.delete();
        lb = '{8'h0F, 8'h0E, 8'h0D};
        send_line(-1);
        lb = '{8'h01, 8'h23};
        send_line(-1);
        drain();
        chk("t3_line_err", 32'(line_err), 32'd1);
        if (got.size() > 0) chk("t3_rgb0", 32'(got[0].rgb), 32'hF0E);
`ifdef OV7670_DECIM2_EN
        chk("t3_count", 32'(got.size()), 32'd1);
`else
        chk("t3_count", 32'(got.size()), 32'd2);
        if (got.size() > 1) begin
            chk("t3_rgb1", 32'(got[1].rgb), 32'h123);
            chk("t3_row1", 32'(got[1].row), 32'd1);
        end
`endif

        // One-cycle reset mid-line
        vs_pulse();
        got.delete(); ready = 0;
        lb = '{8'hAA, 8'hBB, 8'hCC, 8'hDD, 8'hEE, 8'hFF};
        send_line(4);
        chk("t4_en_after_rst", 32'(en), 32'd0);
        chk("t4_ovf_clr", 32'(overflow), 32'd0);
        chk("t4_le_clr", 32'(line_err), 32'd0);
        lb = '{8'h12, 8'h34};
        send_line(-1);
        drain();
        chk("t4_ignored", 32'(got.size()), 32'd0);
        fs_cnt = 0;
        vs_pulse();
        lb = '{8'h05, 8'h67};
        send_line(-1);
        drain();
        chk("t4_count", 32'(got.size()), 32'd1);
        if (got.size() > 0) chk("t4_rgb", 32'(got[0].rgb), 32'h567);
        chk("t4_fs_cnt", 32'(fs_cnt), 32'd1);

        // 4x2 frame closed by vsync
        vs_pulse();
        got.delete(); fd_cnt = 0; ready = 1;
        lb = '{8'h01, 8'h11, 8'h02, 8'h22, 8'h03, 8'h33, 8'h04, 8'h44};
        send_line(-1);
        lb = '{8'h05, 8'h55, 8'h06, 8'h66, 8'h07, 8'h77, 8'h08, 8'h88};
        send_line(-1);
        vs_pulse();
        drain();
        chk("t5_fd_cnt", 32'(fd_cnt), 32'd1);
`ifdef OV7670_DECIM2_EN
        chk("t5_count", 32'(got.size()), 32'd2);
        if (got.size() > 1) begin
            chk("t5_col1", 32'(got[1].col), 32'd1);
            chk("t5_row1", 32'(got[1].row), 32'd0);
            chk("t5_rgb1", 32'(got[1].rgb), 32'h333);
        end
`else
        chk("t5_count", 32'(got.size()), 32'd8);
        if (got.size() > 7) begin
            chk("t5_row3", 32'(got[3].row), 32'd0);
            chk("t5_row4", 32'(got[4].row), 32'd1);
            chk("t5_rgb7", 32'(got[7].rgb), 32'h888);
        end
`endif

        // Long line: column saturates at H-1
        vs_pulse();
        got.delete(); ready = 1;
        lb = '{8'h01, 8'h10, 8'h02, 8'h20, 8'h03, 8'h30, 8'h04, 8'h40, 8'h05, 8'h50, 8'h06, 8'h60};
        send_line(-1);
        drain();
`ifdef OV7670_DECIM2_EN
        chk("t6_count", 32'(got.size()), 32'd2);
`else
        chk("t6_count", 32'(got.size()), 32'd6);
        if (got.size() > 5) chk("t6_col_sat", 32'(got[5].col), 32'd3);
`endif

        // Random frames, random ready
        for (int f = 0; f < 10; f++) begin
            rnd_ready = 1;
            vs_pulse();
            nl = $urandom_range(1, 6);
            for (int l = 0; l < nl; l++) begin
                lb.delete();
                nb = $urandom_range(0, 13);
                for (int j = 0; j < nb; j++) lb.push_back(8'($urandom));
                send_line(-1);
            end
        end
        vs_pulse();
        drain();

        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end

endmodule
